uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame_if.sv | 14 +
 rtl/uart_tx_frame.sv | 159 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
//   Byte handshake between a byte source and uart_tx_frame.
//   i_data  : byte to transmit (source -> transmitter)
//   i_valid : i_data is valid (source -> transmitter)
//   o_ready : transmitter can take a byte this cycle (transmitter -> source)
//   A byte moves on a rising edge where i_valid & o_ready.
interface uart_tx_frame_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Parallel-to-serial UART transmitter, one bit per i_clk cycle.
//   Frame: start(0), d0..d7 LSB first, odd parity (~^data), stop(1).
//   Ports:
//     i_clk  : clock, rising edge
//     i_rst  : synchronous active-high reset (truncates any frame in flight)
//     bus    : slave side of uart_tx_frame_if (i_data/i_valid/o_ready)
//     tx     : registered serial line, idle high
//     o_busy : frame in flight (or, with the FIFO, a byte buffered)
//   Build option:
//     UART_TX_FIFO_EN defined   -> 4-entry input FIFO, back-to-back 11-cycle
//                                  frames, 1 cycle of entry latency.
//     UART_TX_FIFO_EN undefined -> no buffer; the accepting edge starts the
//                                  frame, 12-cycle minimum frame period.
module uart_tx_frame (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_tx_frame_if.slave bus,
    output logic           tx,
    output logic           o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shreg, shreg_nx;
    logic       par, par_nx;
    logic       tx_nx;

    // load: the FSM takes a new byte on this edge (IDLE->START or STOP->START)
    logic       load;
    logic       avail;
    logic [7:0] load_byte;

`ifdef UART_TX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wptr, rptr;
    logic [2:0] cnt;
    logic       full, empty, push, pop;

    assign full        = (cnt == 3'd4);
    assign empty       = (cnt == 3'd0);
    // Readiness depends only on the registered count: a pop on the same
    // edge never frees a slot for a push on that edge.
    assign bus.o_ready = !full & !i_rst;
    assign push        = bus.i_valid & bus.o_ready;
    assign pop         = load;
    assign avail       = !empty;
    assign load_byte   = mem[rptr];
    assign o_busy      = (state != S_IDLE) | !empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr <= 2'd0;
            rptr <= 2'd0;
            cnt  <= 3'd0;
        end else begin
            if (push) wptr <= wptr + 2'd1;
            if (pop)  rptr <= rptr + 2'd1;
            cnt <= cnt + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= bus.i_data;
    end
`else
    // Only IDLE accepts, so a byte is taken on the same edge that enters
    // START; avail can never be true in STOP, which forces the IDLE gap.
    assign bus.o_ready = (state == S_IDLE) & !i_rst;
    assign avail       = bus.i_valid & bus.o_ready;
    assign load_byte   = bus.i_data;
    assign o_busy      = (state != S_IDLE);
`endif

    // tx is registered: each branch sets the line value for the state being
    // entered, so the line changes only on rising edges.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_nx     = par;
        tx_nx      = tx;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nx = 1'b1;
                if (avail) begin
                    load     = 1'b1;
                    state_nx = S_START;
                    tx_nx    = 1'b0;
                end
            end
            S_START: begin
                state_nx   = S_DATA;
                tx_nx      = shreg[0];
                shreg_nx   = {1'b0, shreg[7:1]};
                bit_cnt_nx = 3'd0;
            end
            S_DATA: begin
                if (bit_cnt == 3'd7) begin
                    state_nx = S_PARITY;
                    tx_nx    = par;
                end else begin
                    tx_nx      = shreg[0];
                    shreg_nx   = {1'b0, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                end
            end
            S_PARITY: begin
                state_nx = S_STOP;
                tx_nx    = 1'b1;
            end
            S_STOP: begin
                if (avail) begin
                    load     = 1'b1;
                    state_nx = S_START;
                    tx_nx    = 1'b0;
                end else begin
                    state_nx = S_IDLE;
                    tx_nx    = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tx_nx    = 1'b1;
            end
        endcase
        // Parity is fixed at pop time and held for the rest of the frame.
        if (load) begin
            shreg_nx = load_byte;
            par_nx   = ~^load_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
            par     <= par_nx;
            tx      <= tx_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic tx, o_busy;
    int   checks = 0;
    int   failures = 0;

    uart_tx_frame_if bus();

    uart_tx_frame dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .bus    (bus),
        .tx     (tx),
        .o_busy (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // bit 0 = start, bits 1..8 = d0..d7, bit 9 = odd parity, bit 10 = stop
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Present a byte and return just after the rising edge that accepts it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge i_clk);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        while (!bus.o_ready && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready byte=%h o_ready=%b want 1 within 40 cycles", b, bus.o_ready);
        end
        @(posedge i_clk);
        #1 bus.i_valid = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        checks++;
        if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bus.o_ready); end
        i_rst = 1'b0;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b want=1", bus.o_ready); end
    endtask

    task automatic test_single;
        logic [10:0] exp_bits;
        exp_bits = 11'b111_0100_1010;   // 0xA5: 0,1,0,1,0,0,1,0,1,1,1 from bit 0
        send(8'hA5);
        repeat (LAT) @(negedge i_clk);
        for (int i = 0; i < 11; i++) begin
            @(negedge i_clk);
            checks++;
            if (tx !== exp_bits[i]) begin
                failures++;
                $display("FAIL single_bit%0d got=%b want=%b", i, tx, exp_bits[i]);
            end
            if (i == 0) begin
                checks++;
                if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", o_busy); end
            end
        end
        @(negedge i_clk);
        checks++;
        if (tx !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_after tx=%b busy=%b want tx=1 busy=0", tx, o_busy);
        end
    endtask

    task automatic test_parity;
        logic [7:0] bytes [3];
        logic       want  [3];
        bytes[0] = 8'h00; want[0] = 1'b1;
        bytes[1] = 8'h01; want[1] = 1'b0;
        bytes[2] = 8'hFF; want[2] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            send(bytes[j]);
            repeat (LAT + 9) @(negedge i_clk);
            @(negedge i_clk);
            checks++;
            if (tx !== want[j]) begin
                failures++;
                $display("FAIL parity_%h got=%b want=%b", bytes[j], tx, want[j]);
            end
            repeat (2) @(negedge i_clk);
        end
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_back_to_back;
        logic [7:0] bytes [5];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55;
        send(bytes[0]);
        fork
            begin
                for (int j = 1; j < 5; j++) begin
                    @(negedge i_clk);
                    bus.i_data  = bytes[j];
                    bus.i_valid = 1'b1;
                    checks++;
                    if (bus.o_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL burst_ready%0d got=%b want=1", j, bus.o_ready);
                    end
                    @(posedge i_clk);
                    #1 bus.i_valid = 1'b0;
                end
                // Buffer now holds 4 bytes: further pushes must be refused.
                @(negedge i_clk);
                bus.i_data  = 8'h66;
                bus.i_valid = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (bus.o_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL full_ready cycle%0d got=%b want=0", j, bus.o_ready);
                    end
                    @(negedge i_clk);
                end
                bus.i_valid = 1'b0;
            end
            begin
                logic [10:0] f;
                @(negedge i_clk);
                for (int j = 0; j < 5; j++) begin
                    f = frame_of(bytes[j]);
                    for (int i = 0; i < 11; i++) begin
                        @(negedge i_clk);
                        checks++;
                        if (tx !== f[i]) begin
                            failures++;
                            $display("FAIL burst_frame%0d_bit%0d got=%b want=%b", j, i, tx, f[i]);
                        end
                    end
                end
                for (int i = 0; i < 12; i++) begin
                    @(negedge i_clk);
                    checks++;
                    if (tx !== 1'b1 || o_busy !== 1'b0) begin
                        failures++;
                        $display("FAIL burst_idle%0d tx=%b busy=%b want tx=1 busy=0", i, tx, o_busy);
                    end
                end
            end
        join
    endtask
`else
    task automatic test_no_fifo_period;
        logic [10:0] f1, f2;
        f1 = frame_of(8'h12);
        f2 = frame_of(8'h34);
        @(negedge i_clk);
        bus.i_data  = 8'h12;
        bus.i_valid = 1'b1;
        checks++;
        if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL nofifo_ready0 got=%b want=1", bus.o_ready); end
        @(posedge i_clk);
        #1 bus.i_data = 8'h34;
        for (int i = 0; i < 11; i++) begin
            @(negedge i_clk);
            checks++;
            if (tx !== f1[i] || bus.o_ready !== 1'b0) begin
                failures++;
                $display("FAIL nofifo_f1_bit%0d tx=%b ready=%b want tx=%b ready=0", i, tx, bus.o_ready, f1[i]);
            end
        end
        @(negedge i_clk);
        checks++;
        if (tx !== 1'b1 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL nofifo_gap tx=%b ready=%b want tx=1 ready=1", tx, bus.o_ready);
        end
        @(posedge i_clk);
        #1 bus.i_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge i_clk);
            checks++;
            if (tx !== f2[i] || bus.o_ready !== 1'b0) begin
                failures++;
                $display("FAIL nofifo_f2_bit%0d tx=%b ready=%b want tx=%b ready=0", i, tx, bus.o_ready, f2[i]);
            end
        end
        @(negedge i_clk);
        checks++;
        if (tx !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL nofifo_end tx=%b busy=%b want tx=1 busy=0", tx, o_busy);
        end
    endtask
`endif

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'hB6;                      // d3 = 0
        send(b);
`ifdef UART_TX_FIFO_EN
        for (int j = 0; j < 2; j++) begin
            @(negedge i_clk);
            bus.i_data  = 8'h21 + 8'(j);
            bus.i_valid = 1'b1;
            @(posedge i_clk);
            #1 bus.i_valid = 1'b0;
        end
        repeat (3) @(negedge i_clk);
`else
        repeat (4) @(negedge i_clk);
`endif
        @(negedge i_clk);               // d3 on the line
        checks++;
        if (tx !== b[3]) begin failures++; $display("FAIL midrst_d3 got=%b want=%b", tx, b[3]); end
        i_rst       = 1'b1;
        bus.i_data  = 8'h99;            // presented during reset, must be dropped
        bus.i_valid = 1'b1;
        @(negedge i_clk);
        checks++;
        if (tx !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_cut tx=%b busy=%b want tx=1 busy=0", tx, o_busy);
        end
        checks++;
        if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_in_rst got=%b want=0", bus.o_ready); end
        i_rst       = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_after got=%b want=1", bus.o_ready); end
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            checks++;
            if (tx !== 1'b1 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_quiet%0d tx=%b busy=%b want tx=1 busy=0", i, tx, o_busy);
            end
        end
    endtask

    // Bench-side receiver: samples tx on falling edges like the downstream
    // UART receiver and reports the byte, parity status and stop bit.
    task automatic test_loopback;
        logic [7:0] bytes [4];
        bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h5A; bytes[3] = 8'h80;
        fork
            begin
                for (int j = 0; j < 4; j++) send(bytes[j]);
            end
            begin
                logic [7:0] a;
                logic       p, s;
                int         wait_n;
                bit         lost;
                lost = 1'b0;
                for (int j = 0; j < 4 && !lost; j++) begin
                    wait_n = 0;
                    @(negedge i_clk);
                    while (tx !== 1'b0 && wait_n < 40) begin
                        @(negedge i_clk);
                        wait_n++;
                    end
                    checks++;
                    if (tx !== 1'b0) begin
                        failures++;
                        lost = 1'b1;
                        $display("FAIL loop_start%0d tx=%b want start bit 0 within 40 cycles", j, tx);
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            @(negedge i_clk);
                            a[i] = tx;
                        end
                        @(negedge i_clk); p = tx;
                        @(negedge i_clk); s = tx;
                        checks++;
                        if (a !== bytes[j]) begin
                            failures++;
                            $display("FAIL loop_byte%0d got=%h want=%h", j, a, bytes[j]);
                        end
                        checks++;
                        if ((^{a, p}) !== 1'b1) begin
                            failures++;
                            $display("FAIL loop_iscor%0d data=%h parity=%b want odd total", j, a, p);
                        end
                        checks++;
                        if (s !== 1'b1) begin
                            failures++;
                            $display("FAIL loop_done%0d stop=%b want=1", j, s);
                        end
                    end
                end
            end
        join
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        test_reset();
        test_single();
        test_parity();
`ifdef UART_TX_FIFO_EN
        test_back_to_back();
`else
        test_no_fifo_period();
`endif
        test_reset_mid_frame();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
